// File: rtl/ds_sb_pkg.sv
// Shared types and helpers for the decode-stage register scoreboard.
// Holds the default geometry, the per-register entry type and the
// saturating pending-writer counter update.
package ds_sb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;
  localparam int CNT_W      = 2;
  localparam int PERF_W     = 32;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             ld;
  } sb_entry_t;

  // Issue and retire in the same cycle cancel; the counter never wraps
  // in either direction.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             dec);
    cnt_next = cnt;
    if (inc && !dec && (cnt != CNT_MAX)) begin
      cnt_next = cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt_next = cnt - 1'b1;
    end
  endfunction

endpackage

// File: rtl/ds_scoreboard_ctrl_if.sv
// Decode-stage <-> scoreboard signal bundle. The decode stage is the
// master (drives issue/source/retire information), the scoreboard is the
// slave (returns busy, load-use and go indications).
interface ds_scoreboard_ctrl_if
  import ds_sb_pkg::*;
#(
  parameter int PERF_W = ds_sb_pkg::PERF_W
);
  logic                  issue_fire;
  logic                  issue_we;
  logic [REG_ADDR_W-1:0] issue_dest;
  logic                  issue_load;
  logic                  src1_used;
  logic [REG_ADDR_W-1:0] src1_addr;
  logic                  src2_used;
  logic [REG_ADDR_W-1:0] src2_addr;
  logic                  dst_check;
  logic [REG_ADDR_W-1:0] dst_addr;
  logic                  load_done;
  logic [REG_ADDR_W-1:0] load_done_addr;
  logic                  retire_we;
  logic [REG_ADDR_W-1:0] retire_addr;
  logic                  src1_busy;
  logic                  src2_busy;
  logic                  load_stall;
  logic                  ds_ready_go;
  logic                  sb_err;
  logic [PERF_W-1:0]     stall_cycles;

  modport master (
    output issue_fire, issue_we, issue_dest, issue_load,
    output src1_used, src1_addr, src2_used, src2_addr,
    output dst_check, dst_addr, load_done, load_done_addr,
    output retire_we, retire_addr,
    input  src1_busy, src2_busy, load_stall, ds_ready_go, sb_err, stall_cycles
  );

  modport slave (
    input  issue_fire, issue_we, issue_dest, issue_load,
    input  src1_used, src1_addr, src2_used, src2_addr,
    input  dst_check, dst_addr, load_done, load_done_addr,
    input  retire_we, retire_addr,
    output src1_busy, src2_busy, load_stall, ds_ready_go, sb_err, stall_cycles
  );

endinterface

// File: rtl/sb_entry.sv
// One scoreboard entry: pending-writer counter plus "newest writer is a
// load" flag. err pulses when a retire finds no writer or an issue finds
// the counter already saturated.
module sb_entry
  import ds_sb_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             dec,
  input  logic             ld_set_val,
  input  logic             ld_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ld,
  output logic             err
);

  sb_entry_t st_q;
  sb_entry_t st_d;

  // Next entry state: newest issue defines the load flag, otherwise a
  // retire to zero or forwarded load data clears it.
  always_comb begin
    st_d     = st_q;
    st_d.cnt = cnt_next(st_q.cnt, inc, dec);
    if (inc) begin
      st_d.ld = ld_set_val;
    end else if ((dec && (st_d.cnt == '0)) || ld_clr) begin
      st_d.ld = 1'b0;
    end
  end

  // Entry state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign cnt = st_q.cnt;
  assign ld  = st_q.ld;
  assign err = (inc && !dec && (st_q.cnt == CNT_MAX)) ||
               (dec && !inc && (st_q.cnt == '0));

endmodule

// File: rtl/ds_scoreboard_ctrl.sv
// Register-dependency scoreboard and issue controller for the decode stage.
// Tracks in-flight GPR writes from ID->EX issue to WB retirement and derives
// the decode go signal, per-source busy / load-use flags, a sticky
// consistency error and a stall-cycle counter.
// Build option: DS_SCOREBOARD_FWD_EN -- when defined, only load-use hazards
// and counter saturation stall decode (bypass network covers other busy
// sources); when undefined, any busy source stalls.
module ds_scoreboard_ctrl
  import ds_sb_pkg::*;
#(
  parameter int NREG   = ds_sb_pkg::NREG,
  parameter int PERF_W = ds_sb_pkg::PERF_W
)(
  input  logic                 clk,
  input  logic                 resetn,
  ds_scoreboard_ctrl_if.slave  sb
);

  logic [NREG-1:0][CNT_W-1:0] cnt_v;
  logic [NREG-1:0]            ld_v;
  logic [NREG-1:0]            err_v;

  logic issue_ev;
  logic retire_ev;
  logic src1_busy;
  logic src2_busy;
  logic load_stall;
  logic sat_block;
  logic ready_go;
  logic stalled;

  logic [PERF_W-1:0] stall_cnt_q;
  logic              sb_err_q;

  assign issue_ev  = sb.issue_fire && sb.issue_we && (sb.issue_dest != '0);
  assign retire_ev = sb.retire_we && (sb.retire_addr != '0);

  // r0 is hard-wired idle so reads of it are never busy.
  assign cnt_v[0] = '0;
  assign ld_v[0]  = 1'b0;
  assign err_v[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_ent
    sb_entry u_ent (
      .clk        (clk),
      .resetn     (resetn),
      .inc        (issue_ev  && (sb.issue_dest  == REG_ADDR_W'(i))),
      .dec        (retire_ev && (sb.retire_addr == REG_ADDR_W'(i))),
      .ld_set_val (sb.issue_load),
      .ld_clr     (sb.load_done && (sb.load_done_addr == REG_ADDR_W'(i))),
      .cnt        (cnt_v[i]),
      .ld         (ld_v[i]),
      .err        (err_v[i])
    );
  end

  // Read side: hazards are judged on current state only; a same-cycle
  // retire is covered by regfile write-through on the following cycle.
  always_comb begin
    src1_busy  = sb.src1_used && (cnt_v[sb.src1_addr] != '0);
    src2_busy  = sb.src2_used && (cnt_v[sb.src2_addr] != '0);
    load_stall = (src1_busy && ld_v[sb.src1_addr]) ||
                 (src2_busy && ld_v[sb.src2_addr]);
    sat_block  = sb.dst_check && (cnt_v[sb.dst_addr] == CNT_MAX);
`ifdef DS_SCOREBOARD_FWD_EN
    ready_go   = !load_stall && !sat_block;
`else
    ready_go   = !(src1_busy || src2_busy) && !sat_block;
`endif
    stalled    = !ready_go && (sb.src1_used || sb.src2_used || sb.dst_check);
  end

  // Stall-cycle counter (wraps) and sticky scoreboard error.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      if (stalled) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (|err_v) begin
        sb_err_q <= 1'b1;
      end
    end
  end

  assign sb.src1_busy    = src1_busy;
  assign sb.src2_busy    = src2_busy;
  assign sb.load_stall   = load_stall;
  assign sb.ds_ready_go  = ready_go;
  assign sb.sb_err       = sb_err_q;
  assign sb.stall_cycles = stall_cnt_q;

endmodule
